// File: rtl/sram_line_pkg.sv
// Shared types and elaboration-time helpers for the SRAM line controller.
package sram_line_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        FILL,
        DONE
    } state_t;

    // SRAM beats needed to move one CPU word.
    function automatic int beats_per_word(input int word_w, input int sram_dw);
        return word_w / sram_dw;
    endfunction

    // SRAM beats needed to move one cache line.
    function automatic int beats_per_line(input int word_w, input int sram_dw, input int line_words);
        return line_words * (word_w / sram_dw);
    endfunction

    // Index width for n items; never zero so counters stay declarable.
    function automatic int index_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Exact log2 of a power of two (0 for n == 1).
    function automatic int log2_exact(input int n);
        return $clog2(n);
    endfunction

    // Word must split into whole beats; line length must be a power of two.
    function automatic bit params_legal(input int word_w, input int sram_dw, input int line_words);
        return (sram_dw > 0) && (word_w >= sram_dw) && (word_w % sram_dw == 0) &&
               (line_words >= 1) && ((line_words & (line_words - 1)) == 0);
    endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Beat counter plus wait-state counter shared by the WR and RD bursts.
module sram_beat_timer
    import sram_line_pkg::*;
#(
    parameter int BEAT_W   = 2,
    parameter int WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              run,
    input  logic [BEAT_W-1:0] last_beat,
    output logic [BEAT_W-1:0] beat,
    output logic              beat_last_cycle,
    output logic              burst_done
);

    localparam int                WAIT_W   = index_w(WAIT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_CYC);

    logic [BEAT_W-1:0] beat_q;
    logic [WAIT_W-1:0] wait_q;

    // Restart on burst entry, otherwise hold each beat WAIT_CYC+1 cycles then advance.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            wait_q <= '0;
        end else if (load) begin
            beat_q <= '0;
            wait_q <= '0;
        end else if (run) begin
            if (wait_q == WAIT_MAX) begin
                wait_q <= '0;
                beat_q <= beat_q + 1'b1;
            end else begin
                wait_q <= wait_q + 1'b1;
            end
        end
    end

    assign beat            = beat_q;
    assign beat_last_cycle = run && (wait_q == WAIT_MAX);
    assign burst_done      = beat_last_cycle && (beat_q == last_beat);

endmodule

// File: rtl/sram_line_ctrl.sv
// SRAM controller: serialises word stores into beats and fills whole cache lines.
module sram_line_ctrl
    import sram_line_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int SRAM_DW    = 16,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 2,
    parameter int WAIT_CYC   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_w_en,
    input  logic                         mem_r_en,
    input  logic                         hit,
    input  logic [ADDR_W-1:0]            addr_in,
    input  logic [WORD_W-1:0]            st_value,
    inout  wire  [SRAM_DW-1:0]           sram_dq,
    output logic [ADDR_W-1:0]            sram_addr,
    output logic                         sram_we_n,
    output logic [LINE_WORDS*WORD_W-1:0] line_data,
    output logic [WORD_W-1:0]            read_data,
    output logic                         cache_write,
    output logic                         ready
);

    localparam int R      = beats_per_word(WORD_W, SRAM_DW);
    localparam int LB     = beats_per_line(WORD_W, SRAM_DW, LINE_WORDS);
    localparam int LOG_R  = log2_exact(R);
    localparam int BEAT_W = index_w(LB);
    localparam int WIDX_W = index_w(LINE_WORDS);
    localparam int LINE_W = LINE_WORDS * WORD_W;

    if (!params_legal(WORD_W, SRAM_DW, LINE_WORDS)) begin : g_bad_params
        $error("sram_line_ctrl: WORD_W must be a multiple of SRAM_DW and LINE_WORDS a power of 2");
    end

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat;
    logic                beat_last_cycle, burst_done, timer_load, timer_run;
    logic [BEAT_W-1:0]   last_beat;
    logic [ADDR_W-1:0]   word_base, line_base;
    logic [WIDX_W-1:0]   word_idx;
    logic                dq_drive;
    logic [SRAM_DW-1:0]  dq_out;
    logic [LINE_W-1:0]   asm_q, asm_d;
    logic [WORD_W-1:0]   read_word;

    assign word_base = addr_in & ~ADDR_W'(R - 1);
    assign line_base = addr_in & ~ADDR_W'(LB - 1);
    assign word_idx  = WIDX_W'(addr_in >> LOG_R) & WIDX_W'(LINE_WORDS - 1);

    // Counters restart whenever the FSM enters a burst state from elsewhere.
    assign timer_run  = (state_q == WR) || (state_q == RD);
    assign last_beat  = (state_q == WR) ? BEAT_W'(R - 1) : BEAT_W'(LB - 1);
    assign timer_load = ((state_d == WR) && (state_q != WR)) ||
                        ((state_d == RD) && (state_q != RD));

    sram_beat_timer #(
        .BEAT_W   (BEAT_W),
        .WAIT_CYC (WAIT_CYC)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .load            (timer_load),
        .run             (timer_run),
        .last_beat       (last_beat),
        .beat            (beat),
        .beat_last_cycle (beat_last_cycle),
        .burst_done      (burst_done)
    );

    // State register; an asynchronous reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: stores win over loads, stores write-allocate through RD.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_w_en)             state_d = WR;
                else if (mem_r_en && !hit) state_d = RD;
            end
            WR:      if (burst_done) state_d = RD;
            RD:      if (burst_done) state_d = FILL;
            FILL:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode; only ready in IDLE looks at the request inputs.
    always_comb begin
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        dq_drive    = 1'b0;
        dq_out      = '0;
        cache_write = 1'b0;
        ready       = 1'b0;
        case (state_q)
            IDLE: ready = ~mem_w_en & ~(mem_r_en & ~hit);
            WR: begin
                sram_addr = word_base | ADDR_W'(beat);
                sram_we_n = 1'b0;
                dq_drive  = 1'b1;
                dq_out    = SRAM_DW'(st_value >> (int'(beat) * SRAM_DW));
            end
            RD:      sram_addr = line_base | ADDR_W'(beat);
            FILL:    cache_write = 1'b1;
            DONE:    ready = 1'b1;
            default: ;
        endcase
    end

    assign sram_dq = dq_drive ? dq_out : {SRAM_DW{1'bz}};

    // Slot the bus value into the assembly line on the last cycle of each RD beat.
    always_comb begin
        asm_d = asm_q;
        for (int i = 0; i < LB; i++) begin
            if ((state_q == RD) && beat_last_cycle && (beat == BEAT_W'(i)))
                asm_d[i*SRAM_DW +: SRAM_DW] = sram_dq;
        end
    end

    // Select the requested word from the line being completed.
    always_comb begin
        read_word = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (word_idx == WIDX_W'(i)) read_word = asm_d[i*WORD_W +: WORD_W];
        end
    end

    // Assembly register, and the presented line latched only when the burst completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q     <= '0;
            line_data <= '0;
            read_data <= '0;
        end else begin
            asm_q <= asm_d;
            if ((state_q == RD) && burst_done) begin
                line_data <= asm_d;
                read_data <= read_word;
            end
        end
    end

endmodule
